// File: rtl/jk_ctrl_pkg.sv
// jk_ctrl_pkg: opcodes and FSM encodings shared by the JK counter controller
package jk_ctrl_pkg;
    localparam logic [1:0] OP_HOLD  = 2'd0;
    localparam logic [1:0] OP_CLEAR = 2'd1;
    localparam logic [1:0] OP_LOAD  = 2'd2;
    localparam logic [1:0] OP_COUNT = 2'd3;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
endpackage

// File: rtl/jk_ff.sv
// jk_ff: single JK flip-flop storage cell with no reset port
module jk_ff (
    input  logic clk,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(posedge clk)
        q <= (j & k) ? ~q : j ? 1'b1 : k ? 1'b0 : q;
endmodule

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH independent JK cells driven by per-bit excitation
module jk_reg_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q
);
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_ff u_ff (.clk(clk), .j(j[g]), .k(k[g]), .q(q[g]));
    end
endmodule

// File: rtl/jk_counter_ctrl.sv
// jk_counter_ctrl: command-driven up/down counter built from a JK bank
// Reset is applied through J/K excitation because the cells have no reset.
module jk_counter_ctrl #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);
    import jk_ctrl_pkg::*;

    logic [1:0]       state;
    logic [1:0]       op;
    logic             dir;
    logic [WIDTH-1:0] data;
    logic [LEN_W-1:0] remaining;
    logic [WIDTH-1:0] j, k, t;
    logic             up_c, dn_c;

    assign cmd_ready = (state == IDLE) & ~rst;
    assign busy      = state != IDLE;

    // Toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down)
    always_comb begin
        up_c = 1'b1;
        dn_c = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t[i] = dir ? up_c : dn_c;
            up_c = up_c & q[i];
            dn_c = dn_c & ~q[i];
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        if (rst) k = '1;
        else if (state == EXEC && op == OP_CLEAR) k = '1;
        else if (state == EXEC && op == OP_LOAD) begin
            j = data;
            k = ~data;
        end
        else if (state == RUN && !cmd_abort) begin
            j = t;
            k = t;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            done      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            if (state == IDLE) begin
                if (cmd_valid) begin
                    op        <= cmd_op;
                    dir       <= cmd_dir;
                    data      <= cmd_data;
                    remaining <= cmd_len;
                    state     <= (cmd_op == OP_COUNT && cmd_len != '0) ? RUN : EXEC;
                end
            end else if (state == RUN) begin
                remaining <= remaining - LEN_W'(1);
                wrap      <= ~cmd_abort & (dir ? &q : ~|q);
                if (cmd_abort || remaining == LEN_W'(1)) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
            end else begin
                state <= IDLE;
                done  <= (state == EXEC);
            end
        end
    end

    jk_reg_bank #(.WIDTH(WIDTH)) u_bank (.clk(clk), .j(j), .k(k), .q(q));
endmodule

// File: tb/tb_jk_counter_ctrl.sv
// tb_jk_counter_ctrl: directed and randomized checks of jk_counter_ctrl
// against a command-level arithmetic model of the counter.
module tb_jk_counter_ctrl;
    localparam int WIDTH = 4;
    localparam int LEN_W = 8;
    localparam int MOD   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic             cmd_dir = 1'b0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             cmd_abort = 1'b0;
    logic [WIDTH-1:0] q;
    logic             busy, done, wrap;

    int vectors = 0;
    int errors  = 0;
    int wraps   = 0;

    // model state: counter value and pending command
    bit m_valid = 0;
    int m_q, m_left, m_op, m_data;
    bit m_busy, m_run, m_up, m_done, m_wrap;

    jk_counter_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_data(cmd_data), .cmd_len(cmd_len),
        .cmd_abort(cmd_abort), .q(q), .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1;
            m_q <= 0;
            m_busy <= 0;
            m_done <= 0;
            m_wrap <= 0;
        end else if (!m_busy) begin
            m_done <= 0;
            m_wrap <= 0;
            if (cmd_valid) begin
                m_busy <= 1;
                m_op   <= cmd_op;
                m_up   <= cmd_dir;
                m_data <= cmd_data;
                m_left <= cmd_len;
                m_run  <= cmd_op == 3 && cmd_len != 0;
            end
        end else if (!m_run) begin
            m_busy <= 0;
            m_done <= 1;
            m_wrap <= 0;
            if (m_op == 1) m_q <= 0;
            else if (m_op == 2) m_q <= m_data;
        end else if (cmd_abort) begin
            m_busy <= 0;
            m_done <= 1;
            m_wrap <= 0;
        end else begin
            m_q    <= m_up ? (m_q + 1) % MOD : (m_q + MOD - 1) % MOD;
            m_wrap <= m_up ? (m_q == MOD - 1) : (m_q == 0);
            m_left <= m_left - 1;
            m_busy <= m_left > 1;
            m_done <= m_left == 1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (wrap === 1'b1) wraps++;
        if (m_valid) begin
            chk("q", q, m_q);
            chk("busy", busy, m_busy);
            chk("cmd_ready", cmd_ready, !m_busy && !rst);
            chk("done", done, m_done);
            chk("wrap", wrap, m_wrap);
        end
    end

    task automatic send(input logic [1:0] op, input logic dir, input int data, input int len);
        cmd_valid = 1;
        cmd_op    = op;
        cmd_dir   = dir;
        cmd_data  = WIDTH'(data);
        cmd_len   = LEN_W'(len);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        int w0;
        logic [WIDTH-1:0] q0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_q", q, 0);
        chk("reset_busy", busy, 0);
        rst = 0;
        #1;
        chk("reset_ready", cmd_ready, 1);
        @(negedge clk);

        send(2, 0, 4'b1010, 0);
        @(negedge clk);
        chk("load_q", q, 4'b1010);
        chk("load_done", done, 1);
        chk("load_wrap", wrap, 0);
        @(negedge clk);
        chk("load_done_once", done, 0);

        w0 = wraps;
        send(3, 1, 0, 7);
        wait_idle();
        chk("up_done", done, 1);
        chk("up_q", q, 4'b0001);
        chk("up_wraps", wraps - w0, 1);
        @(negedge clk);

        w0 = wraps;
        send(3, 0, 0, 2);
        wait_idle();
        chk("down_q", q, 4'b1111);
        chk("down_wraps", wraps - w0, 1);
        @(negedge clk);

        send(1, 0, 0, 0);
        wait_idle();
        chk("clear_q", q, 0);
        @(negedge clk);

        send(3, 1, 0, 10);
        repeat (3) @(negedge clk);
        cmd_abort = 1;
        @(negedge clk);
        cmd_abort = 0;
        chk("abort_q", q, 4'b0011);
        chk("abort_done", done, 1);
        chk("abort_busy", busy, 0);
        @(negedge clk);

        send(3, 1, 0, 10);
        cmd_valid = 1;
        cmd_op    = 2;
        cmd_data  = 4'b0110;
        repeat (3) @(negedge clk);
        chk("busy_ignore", busy, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        cmd_valid = 0;
        #1;
        chk("rst_run_q", q, 0);
        chk("rst_run_done", done, 0);
        chk("rst_run_ready", cmd_ready, 1);
        @(negedge clk);
        q0 = q;
        send(3, 1, 0, 0);
        @(negedge clk);
        chk("len0_q", q, q0);
        chk("len0_done", done, 1);

        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            rst       = $urandom_range(0, 59) == 0;
            cmd_valid = $urandom_range(0, 2) == 0;
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_dir   = 1'($urandom_range(0, 1));
            cmd_data  = WIDTH'($urandom);
            cmd_len   = LEN_W'($urandom_range(0, 20));
            cmd_abort = $urandom_range(0, 11) == 0;
        end
        @(negedge clk);
        rst = 0;
        cmd_valid = 0;
        cmd_abort = 0;
        repeat (30) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
